// File: rtl/lc2k_pkg.sv
// LC-2K shared definitions: opcodes, field positions, type classification,
// word encoding and the encoder FSM states. Also used by the decoder.
package lc2k_pkg;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] NOR  = 3'b001;
   localparam logic [2:0] LW   = 3'b010;
   localparam logic [2:0] SW   = 3'b011;
   localparam logic [2:0] BEQ  = 3'b100;
   localparam logic [2:0] JALR = 3'b101;
   localparam logic [2:0] HALT = 3'b110;
   localparam logic [2:0] NOOP = 3'b111;

   localparam int unsigned OPC_LSB  = 22;
   localparam int unsigned REGA_LSB = 19;
   localparam int unsigned REGB_LSB = 16;
   localparam int unsigned DEST_LSB = 0;
   localparam int unsigned OFF_LSB  = 0;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_FIELD = 2'b01;
   localparam logic [1:0] ERR_OVFL  = 2'b10;

   typedef enum logic [1:0] {ITYPE_R, ITYPE_I, ITYPE_J, ITYPE_O} itype_t;

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} state_t;

   function automatic itype_t instr_type(input logic [2:0] opcode);
      itype_t t;
      case (opcode)
         ADD, NOR:     t = ITYPE_R;
         LW, SW, BEQ:  t = ITYPE_I;
         JALR:         t = ITYPE_J;
         default:      t = ITYPE_O;
      endcase
      return t;
   endfunction

   // Unused fields of each format are forced to zero.
   function automatic logic [31:0] encode_word(input logic [2:0]  opcode,
                                               input logic [2:0]  rega,
                                               input logic [2:0]  regb,
                                               input logic [2:0]  dest,
                                               input logic [15:0] offset);
      logic [31:0] w;
      w = '0;
      w[OPC_LSB +: 3] = opcode;
      case (instr_type(opcode))
         ITYPE_R: begin
            w[REGA_LSB +: 3] = rega;
            w[REGB_LSB +: 3] = regb;
            w[DEST_LSB +: 3] = dest;
         end
         ITYPE_I: begin
            w[REGA_LSB +: 3] = rega;
            w[REGB_LSB +: 3] = regb;
            w[OFF_LSB +: 16] = offset;
         end
         ITYPE_J: begin
            w[REGA_LSB +: 3] = rega;
            w[REGB_LSB +: 3] = regb;
         end
         default: ;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_field_check.sv
// Combinational legality check of the unused fields of an instruction.
module instr_field_check
   import lc2k_pkg::*;
(
   input  logic [2:0]  opcode,
   input  logic [2:0]  regA,
   input  logic [2:0]  regB,
   input  logic [15:0] offset,
   output logic        illegal
);

   // Flag nonzero offset on R/J/O formats and nonzero registers on O format.
   always_comb begin
      illegal = 1'b0;
      case (instr_type(opcode))
         ITYPE_R, ITYPE_J: illegal = |offset;
         ITYPE_O:          illegal = (|offset) || (|regA) || (|regB);
         default:          illegal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// LC-2K instruction encoder: packs instruction fields into 32-bit words and
// writes them sequentially into instruction memory from address 0.
// Optional macro ENC_FIELD_CHECK_EN rejects instructions with nonzero
// unused fields (err_code 01) instead of silently masking them.
module instr_encoder
   import lc2k_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 65536,
   parameter int unsigned ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_opcode,
   input  logic [2:0]        in_regA,
   input  logic [2:0]        in_regB,
   input  logic [2:0]        in_destReg,
   input  logic [15:0]       in_offset,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

   state_t          state, nstate;
   logic [ADDR_W:0] acc_cnt;
   logic            accept, wr_fire, field_bad;
   logic            load, restart, set_err, set_done;
   logic [1:0]      err_n;
   logic [31:0]     enc;

`ifdef ENC_FIELD_CHECK_EN
   instr_field_check u_chk (
      .opcode  (in_opcode),
      .regA    (in_regA),
      .regB    (in_regB),
      .offset  (in_offset),
      .illegal (field_bad)
   );
`else
   assign field_bad = 1'b0;
`endif

   assign in_ready = (state == RUN) && (!wr_valid || wr_ready);
   assign accept   = in_valid && in_ready;
   assign wr_fire  = wr_valid && wr_ready;
   assign enc      = encode_word(in_opcode, in_regA, in_regB, in_destReg, in_offset);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   // Next state and datapath controls; field error outranks overflow.
   always_comb begin
      nstate   = state;
      load     = 1'b0;
      restart  = 1'b0;
      set_err  = 1'b0;
      set_done = 1'b0;
      err_n    = ERR_NONE;
      unique case (state)
         IDLE, DONE, ERR: begin
            if (start) begin
               nstate  = RUN;
               restart = 1'b1;
            end
         end
         RUN: begin
            if (accept) begin
               if (field_bad) begin
                  nstate  = ERR;
                  set_err = 1'b1;
                  err_n   = ERR_FIELD;
               end else if (acc_cnt == DEPTH_C) begin
                  nstate  = ERR;
                  set_err = 1'b1;
                  err_n   = ERR_OVFL;
               end else begin
                  load = 1'b1;
                  if (in_opcode == HALT) nstate = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (wr_fire) begin
               nstate   = DONE;
               set_done = 1'b1;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   // Write port, counters and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         acc_cnt  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else if (restart) begin
         // A word still pending from an errored load is dropped so the new
         // program cleanly begins at address 0.
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         acc_cnt  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         if (wr_fire && (wr_addr != '1)) wr_addr <= wr_addr + ADDR_W'(1);
         if (load) begin
            wr_valid <= 1'b1;
            wr_data  <= enc;
            acc_cnt  <= acc_cnt + (ADDR_W+1)'(1);
         end else if (wr_fire) begin
            wr_valid <= 1'b0;
         end
         if (set_err) begin
            err      <= 1'b1;
            err_code <= err_n;
         end
         if (set_done) done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (MEM_DEPTH overridden to 4).
// Expected writes are queued when an instruction is accepted and popped by a
// write monitor when the DUT completes a memory write.
module tb_instr_encoder;
   import lc2k_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready;
   logic [2:0]  in_opcode, in_regA, in_regB, in_destReg;
   logic [15:0] in_offset;
   logic        wr_valid, wr_ready;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   logic        done, err;
   logic [1:0]  err_code;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         sb[$];
   wr_t         mon_e;
   logic [15:0] exp_addr;
   int          n_tests = 0;
   int          n_fail  = 0;

   instr_encoder #(.MEM_DEPTH(4), .ADDR_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_regA    (in_regA),
      .in_regB    (in_regB),
      .in_destReg (in_destReg),
      .in_offset  (in_offset),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   // Reference encoding of the LC-2K word formats.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [2:0] a,
                                         input logic [2:0] b, input logic [2:0] d,
                                         input logic [15:0] off);
      logic [31:0] w;
      w = {7'd0, op, 22'd0};
      if (op <= 3'd1)      w[21:0] = {a, b, 13'd0, d};
      else if (op <= 3'd4) w[21:0] = {a, b, off};
      else if (op == 3'd5) w[21:0] = {a, b, 16'd0};
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered just after a rising edge; leaves just after the next one.
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_addr = '0;
   endtask

   // Entered just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic [15:0] off,
                       input bit expect_wr, input logic [31:0] exp_data);
      int waited;
      in_valid = 1'b1;
      in_opcode = op; in_regA = a; in_regB = b; in_destReg = d; in_offset = off;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      check("accept_ready", {31'd0, in_ready}, 32'd1);
      if (in_ready && expect_wr) begin
         sb.push_back('{addr: exp_addr, data: exp_data});
         exp_addr++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Every completed write must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && wr_valid && wr_ready) begin
         n_tests++;
         assert (sb.size() != 0)
         else begin
            n_fail++;
            $error("FAIL unexpected_write: observed addr %h data %h, required no write",
                   wr_addr, wr_data);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("mon_wr_addr", {16'd0, wr_addr}, {16'd0, mon_e.addr});
            check("mon_wr_data", wr_data, mon_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
      in_opcode = '0; in_regA = '0; in_regB = '0; in_destReg = '0; in_offset = '0;
      exp_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("rst_wr_addr",  {16'd0, wr_addr}, 32'd0);
      check("rst_wr_data",  wr_data, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_done",     {31'd0, done}, 32'd0);
      check("rst_err",      {31'd0, err}, 32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      rst = 1'b0;
      tick();

      // Program 1: add, lw, nor, then halt under write backpressure.
      pulse_start();
      send(ADD, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1, 32'h000A0003);
      @(negedge clk);
      check("add_wr_valid", {31'd0, wr_valid}, 32'd1);
      check("add_wr_addr",  {16'd0, wr_addr}, 32'd0);
      check("add_wr_data",  wr_data, 32'h000A0003);
      tick();
      send(LW, 3'd0, 3'd1, 3'd0, 16'hFFFF, 1'b1, 32'h0081FFFF);
      @(negedge clk);
      check("lw_wr_addr", {16'd0, wr_addr}, 32'd1);
      check("lw_wr_data", wr_data, 32'h0081FFFF);
      tick();
      send(NOR, 3'd7, 3'd7, 3'd7, 16'h0000, 1'b1, model(NOR, 3'd7, 3'd7, 3'd7, 16'h0000));
      send(HALT, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 32'h01800000);
      wr_ready = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         @(negedge clk);
         check("halt_stall_valid", {31'd0, wr_valid}, 32'd1);
         check("halt_stall_data",  wr_data, 32'h01800000);
         check("halt_stall_addr",  {16'd0, wr_addr}, 32'd3);
         check("halt_stall_ready", {31'd0, in_ready}, 32'd0);
         check("halt_stall_done",  {31'd0, done}, 32'd0);
         tick();
      end
      wr_ready = 1'b1;
      @(negedge clk);
      check("halt_done_pre", {31'd0, done}, 32'd0);
      tick();
      @(negedge clk);
      check("halt_done",     {31'd0, done}, 32'd1);
      check("halt_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("halt_in_ready", {31'd0, in_ready}, 32'd0);
      tick();

      // Program 2: five back-to-back instructions into a four-word memory.
      pulse_start();
      @(negedge clk);
      check("restart_done",    {31'd0, done}, 32'd0);
      check("restart_wr_addr", {16'd0, wr_addr}, 32'd0);
      tick();
      send(SW,   3'd1, 3'd2, 3'd0, 16'h8000, 1'b1, model(SW,   3'd1, 3'd2, 3'd0, 16'h8000));
      send(BEQ,  3'd3, 3'd4, 3'd0, 16'h0010, 1'b1, model(BEQ,  3'd3, 3'd4, 3'd0, 16'h0010));
      send(JALR, 3'd5, 3'd6, 3'd0, 16'h0000, 1'b1, model(JALR, 3'd5, 3'd6, 3'd0, 16'h0000));
      send(NOOP, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 32'h01C00000);
      send(ADD,  3'd7, 3'd0, 3'd1, 16'h0000, 1'b0, 32'h0);
      @(negedge clk);
      check("ovf_err",      {31'd0, err}, 32'd1);
      check("ovf_err_code", {30'd0, err_code}, 32'd2);
      check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
      check("ovf_wr_valid", {31'd0, wr_valid}, 32'd0);
      tick();
      tick();
      check("ovf_all_written", sb.size(), 32'd0);

      // Program 3: noop carrying a nonzero offset.
      pulse_start();
`ifdef ENC_FIELD_CHECK_EN
      send(NOOP, 3'd0, 3'd0, 3'd0, 16'd5, 1'b0, 32'h0);
      @(negedge clk);
      check("noop_off_err",      {31'd0, err}, 32'd1);
      check("noop_off_err_code", {30'd0, err_code}, 32'd1);
      check("noop_off_wr_valid", {31'd0, wr_valid}, 32'd0);
      tick();
`else
      send(NOOP, 3'd0, 3'd0, 3'd0, 16'd5, 1'b1, 32'h01C00000);
      @(negedge clk);
      check("noop_off_wr_valid", {31'd0, wr_valid}, 32'd1);
      check("noop_off_wr_data",  wr_data, 32'h01C00000);
      check("noop_off_err_code", {30'd0, err_code}, 32'd0);
      tick();
      send(HALT, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 32'h01800000);
      tick();
      @(negedge clk);
      check("noop_prog_done", {31'd0, done}, 32'd1);
      tick();
`endif

      // Program 4: illegal fifth word, so both error causes coincide.
      pulse_start();
      send(BEQ,  3'd1, 3'd1, 3'd0, 16'hFFFE, 1'b1, model(BEQ,  3'd1, 3'd1, 3'd0, 16'hFFFE));
      send(SW,   3'd4, 3'd5, 3'd0, 16'h1234, 1'b1, model(SW,   3'd4, 3'd5, 3'd0, 16'h1234));
      send(NOR,  3'd2, 3'd3, 3'd4, 16'h0000, 1'b1, model(NOR,  3'd2, 3'd3, 3'd4, 16'h0000));
      send(JALR, 3'd6, 3'd7, 3'd0, 16'h0000, 1'b1, model(JALR, 3'd6, 3'd7, 3'd0, 16'h0000));
      send(NOOP, 3'd0, 3'd0, 3'd0, 16'd5, 1'b0, 32'h0);
      @(negedge clk);
      check("prio_err", {31'd0, err}, 32'd1);
`ifdef ENC_FIELD_CHECK_EN
      check("prio_err_code", {30'd0, err_code}, 32'd1);
`else
      check("prio_err_code", {30'd0, err_code}, 32'd2);
`endif
      tick();
      tick();
      check("prio_all_written", sb.size(), 32'd0);

      // Program 5: reset (with a coincident start) while a write is stalled.
      pulse_start();
      wr_ready = 1'b0;
      send(ADD, 3'd1, 3'd1, 3'd1, 16'h0000, 1'b1, model(ADD, 3'd1, 3'd1, 3'd1, 16'h0000));
      @(negedge clk);
      check("midrst_pending", {31'd0, wr_valid}, 32'd1);
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      sb.delete();
      @(negedge clk);
      check("midrst_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("midrst_wr_addr",  {16'd0, wr_addr}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_err",      {31'd0, err}, 32'd0);
      wr_ready = 1'b1;
      tick();
      pulse_start();
      send(LW, 3'd0, 3'd1, 3'd0, 16'hFFFF, 1'b1, 32'h0081FFFF);
      @(negedge clk);
      check("post_rst_wr_addr", {16'd0, wr_addr}, 32'd0);
      check("post_rst_wr_data", wr_data, 32'h0081FFFF);
      tick();
      tick();
      check("post_rst_all_written", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
